// File: rtl/lza_norm_corrector_if.sv
// Handshake and data bundle between the add/subtract control FSM (master)
// and the LZA normalization corrector (slave).
interface lza_norm_corrector_if #(
    parameter int SWR = 26,
    parameter int EW  = 8
);
    logic           load_i;
    logic [SWR-1:0] Sgf_i;
    logic [EW-1:0]  Exp_i;
    logic [EW-1:0]  Shift_Value_i;
    logic           ack_i;
    logic           ready_o;
    logic           done_o;
    logic [SWR-1:0] Sgf_o;
    logic [EW-1:0]  Exp_o;
    logic           zero_o;
    logic           underflow_o;
    logic           lza_err_o;

    modport master (
        output load_i, Sgf_i, Exp_i, Shift_Value_i, ack_i,
        input  ready_o, done_o, Sgf_o, Exp_o, zero_o, underflow_o, lza_err_o
    );

    modport slave (
        input  load_i, Sgf_i, Exp_i, Shift_Value_i, ack_i,
        output ready_o, done_o, Sgf_o, Exp_o, zero_o, underflow_o, lza_err_o
    );
endinterface

// File: rtl/lza_norm_corrector.sv
// Normalizes the adder significand using the LZA shift prediction, fixes the
// one-position underestimate, and adjusts the exponent.
module lza_norm_corrector #(
    parameter int SWR = 26,
    parameter int EW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    lza_norm_corrector_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, CORRECT, DONE} state_t;

    localparam logic [EW-1:0] MAX_SHAMT = EW'(SWR - 1);

    state_t         state_q, state_d;
    logic [SWR-1:0] sgf_q, sgf_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic [EW-1:0]  shv_q, shv_d;
    logic [EW:0]    expt_q, expt_d;
    logic [SWR-1:0] sgf_o_q, sgf_o_d;
    logic [EW-1:0]  exp_o_q, exp_o_d;
    logic           zero_q, zero_d;
    logic           uf_q, uf_d;
    logic           err_q, err_d;

    logic [EW-1:0]  shamt;
    logic [SWR-1:0] fin_sgf;
    logic [EW:0]    fin_exp;
    logic           fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sgf_q   <= '0;
            exp_q   <= '0;
            shv_q   <= '0;
            expt_q  <= '0;
            sgf_o_q <= '0;
            exp_o_q <= '0;
            zero_q  <= 1'b0;
            uf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgf_q   <= sgf_d;
            exp_q   <= exp_d;
            shv_q   <= shv_d;
            expt_q  <= expt_d;
            sgf_o_q <= sgf_o_d;
            exp_o_q <= exp_o_d;
            zero_q  <= zero_d;
            uf_q    <= uf_d;
            err_q   <= err_d;
        end
    end

    // The predicted count is clamped so a corrupt prediction cannot shift
    // the whole significand out.
    always_comb begin
        state_d = state_q;
        sgf_d   = sgf_q;
        exp_d   = exp_q;
        shv_d   = shv_q;
        expt_d  = expt_q;
        sgf_o_d = sgf_o_q;
        exp_o_d = exp_o_q;
        zero_d  = zero_q;
        uf_d    = uf_q;
        err_d   = err_q;
        fin     = 1'b0;
        fin_sgf = sgf_q;
        fin_exp = expt_q;
        shamt   = (shv_q > MAX_SHAMT) ? MAX_SHAMT : shv_q;

        case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    sgf_d  = bus.Sgf_i;
                    exp_d  = bus.Exp_i;
                    shv_d  = bus.Shift_Value_i;
                    zero_d = 1'b0;
                    uf_d   = 1'b0;
                    err_d  = 1'b0;
                    if (bus.Sgf_i == '0) begin
                        sgf_o_d = '0;
                        exp_o_d = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sgf_d   = sgf_q << shamt;
                expt_d  = {1'b0, exp_q} - {1'b0, shamt};
                state_d = CHECK;
            end
            CHECK: begin
                if (sgf_q[SWR-1]) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                fin_sgf = sgf_q << 1;
                fin_exp = expt_q - 1'b1;
                sgf_d   = fin_sgf;
                expt_d  = fin_exp;
                err_d   = ~fin_sgf[SWR-1];
                fin     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A negative (sign bit) or zero adjusted exponent is an underflow.
        if (fin) begin
            sgf_o_d = fin_sgf;
            if (fin_exp[EW] || fin_exp == '0) begin
                exp_o_d = '0;
                uf_d    = 1'b1;
            end else begin
                exp_o_d = fin_exp[EW-1:0];
            end
        end
    end

    assign bus.ready_o     = (state_q == IDLE);
    assign bus.done_o      = (state_q == DONE);
    assign bus.Sgf_o       = sgf_o_q;
    assign bus.Exp_o       = exp_o_q;
    assign bus.zero_o      = zero_q;
    assign bus.underflow_o = uf_q;
    assign bus.lza_err_o   = err_q;
endmodule

// File: tb/tb_lza_norm_corrector.sv
// Directed self-checking bench for lza_norm_corrector: latency, correction,
// zero, underflow, out-of-range prediction, handshake and reset behaviour.
module tb_lza_norm_corrector;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    lza_norm_corrector_if #(.SWR(26), .EW(8)) bus ();

    lza_norm_corrector #(.SWR(26), .EW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads one operand set and returns the cycle count until done_o rises.
    task automatic run_op(input logic [25:0] sgf, input logic [7:0] exp,
                          input logic [7:0] shv, output int lat,
                          output logic rdy_after);
        @(negedge clk);
        bus.Sgf_i         = sgf;
        bus.Exp_i         = exp;
        bus.Shift_Value_i = shv;
        bus.load_i        = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        @(negedge clk);
        rdy_after = bus.ready_o;
        lat = 1;
        while (!bus.done_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done_o) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL done_timeout: done_o=%0b after %0d cycles, required 1", bus.done_o, lat);
        end
    endtask

    task automatic acknowledge();
        @(negedge clk);
        bus.ack_i = 1'b1;
        @(posedge clk);
        #1 bus.ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: ready=%b done=%b, required ready=1 done=0", bus.ready_o, bus.done_o);
        end
        n_checks++;
        if (bus.Sgf_o !== 26'h0 || bus.Exp_o !== 8'h0 ||
            {bus.zero_o, bus.underflow_o, bus.lza_err_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_data: Sgf=%h Exp=%0d flags=%b%b%b, required all 0",
                     bus.Sgf_o, bus.Exp_o, bus.zero_o, bus.underflow_o, bus.lza_err_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int lat;
        logic rdy;
        run_op(26'h0200000, 8'd100, 8'd4, lat, rdy);
        n_checks++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL normal_ready_low: ready=%b, required 0", rdy);
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("[TB] FAIL normal_latency: got %0d, required 3", lat);
        end
        n_checks++;
        if (bus.Sgf_o !== 26'h2000000 || bus.Exp_o !== 8'd96) begin
            n_fail++;
            $display("[TB] FAIL normal_result: Sgf=%h Exp=%0d, required 2000000/96", bus.Sgf_o, bus.Exp_o);
        end
        n_checks++;
        if ({bus.zero_o, bus.underflow_o, bus.lza_err_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL normal_flags: got %b%b%b, required 000", bus.zero_o, bus.underflow_o, bus.lza_err_o);
        end
        acknowledge();
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.Sgf_o !== 26'h2000000) begin
            n_fail++;
            $display("[TB] FAIL normal_ack: ready=%b done=%b Sgf=%h, required 1/0/2000000", bus.ready_o, bus.done_o, bus.Sgf_o);
        end
    endtask

    task automatic test_correction();
        int lat;
        logic rdy;
        run_op(26'h0200000, 8'd100, 8'd3, lat, rdy);
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("[TB] FAIL corr_latency: got %0d, required 4", lat);
        end
        n_checks++;
        if (bus.Sgf_o !== 26'h2000000 || bus.Exp_o !== 8'd96 || bus.lza_err_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL corr_result: Sgf=%h Exp=%0d err=%b, required 2000000/96/0", bus.Sgf_o, bus.Exp_o, bus.lza_err_o);
        end
        acknowledge();
    endtask

    task automatic test_zero();
        int lat;
        logic rdy;
        run_op(26'h0, 8'd77, 8'd5, lat, rdy);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("[TB] FAIL zero_latency: got %0d, required 1", lat);
        end
        n_checks++;
        if (bus.zero_o !== 1'b1 || bus.Sgf_o !== 26'h0 || bus.Exp_o !== 8'd0 || bus.underflow_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_result: zero=%b Sgf=%h Exp=%0d uf=%b, required 1/0/0/0", bus.zero_o, bus.Sgf_o, bus.Exp_o, bus.underflow_o);
        end
        acknowledge();
    endtask

    task automatic test_underflow();
        int lat;
        logic rdy;
        run_op(26'h0200000, 8'd3, 8'd4, lat, rdy);
        n_checks++;
        if (bus.underflow_o !== 1'b1 || bus.Exp_o !== 8'd0 || bus.Sgf_o !== 26'h2000000 || bus.zero_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL uf_neg: uf=%b Exp=%0d Sgf=%h zero=%b, required 1/0/2000000/0", bus.underflow_o, bus.Exp_o, bus.Sgf_o, bus.zero_o);
        end
        acknowledge();
        run_op(26'h0200000, 8'd4, 8'd4, lat, rdy);
        n_checks++;
        if (bus.underflow_o !== 1'b1 || bus.Exp_o !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL uf_zero: uf=%b Exp=%0d, required 1/0", bus.underflow_o, bus.Exp_o);
        end
        acknowledge();
        run_op(26'h0200000, 8'd5, 8'd4, lat, rdy);
        n_checks++;
        if (bus.underflow_o !== 1'b0 || bus.Exp_o !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL uf_edge_one: uf=%b Exp=%0d, required 0/1", bus.underflow_o, bus.Exp_o);
        end
        acknowledge();
    endtask

    task automatic test_lza_err();
        int lat;
        logic rdy;
        run_op(26'h0200000, 8'd100, 8'd2, lat, rdy);
        n_checks++;
        if (bus.lza_err_o !== 1'b1 || bus.Sgf_o !== 26'h1000000 || bus.Exp_o !== 8'd97 || lat != 4) begin
            n_fail++;
            $display("[TB] FAIL lza_err: err=%b Sgf=%h Exp=%0d lat=%0d, required 1/1000000/97/4", bus.lza_err_o, bus.Sgf_o, bus.Exp_o, lat);
        end
        acknowledge();
    endtask

    task automatic test_handshake();
        int lat;
        logic rdy;
        run_op(26'h0000400, 8'd200, 8'd15, lat, rdy);
        n_checks++;
        if (bus.Sgf_o !== 26'h2000000 || bus.Exp_o !== 8'd185) begin
            n_fail++;
            $display("[TB] FAIL hs_result: Sgf=%h Exp=%0d, required 2000000/185", bus.Sgf_o, bus.Exp_o);
        end
        for (int i = 0; i < 5; i++) begin
            bus.load_i        = 1'b1;
            bus.Sgf_i         = 26'h0;
            bus.Exp_i         = 8'd11;
            bus.Shift_Value_i = 8'd1;
            @(negedge clk);
            n_checks++;
            if (bus.done_o !== 1'b1 || bus.Sgf_o !== 26'h2000000 || bus.Exp_o !== 8'd185 || bus.zero_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hs_hold_%0d: done=%b Sgf=%h Exp=%0d zero=%b, required 1/2000000/185/0",
                         i, bus.done_o, bus.Sgf_o, bus.Exp_o, bus.zero_o);
            end
        end
        bus.load_i = 1'b1;
        bus.Sgf_i  = 26'h0;
        bus.ack_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.load_i = 1'b0;
        bus.ack_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.zero_o !== 1'b0 || bus.Exp_o !== 8'd185) begin
            n_fail++;
            $display("[TB] FAIL hs_ack_load: ready=%b done=%b zero=%b Exp=%0d, required 1/0/0/185",
                     bus.ready_o, bus.done_o, bus.zero_o, bus.Exp_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic rdy;
        bus.ack_i = 1'b1;
        run_op(26'h0200000, 8'd100, 8'd4, lat, rdy);
        run_op(26'h0100000, 8'd50, 8'd5, lat, rdy);
        n_checks++;
        if (lat != 3 || bus.Sgf_o !== 26'h2000000 || bus.Exp_o !== 8'd45) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: lat=%0d Sgf=%h Exp=%0d, required 3/2000000/45", lat, bus.Sgf_o, bus.Exp_o);
        end
        @(posedge clk);
        #1 bus.ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.Sgf_i         = 26'h0200000;
        bus.Exp_i         = 8'd100;
        bus.Shift_Value_i = 8'd4;
        bus.load_i        = 1'b1;
        @(posedge clk);
        #1 bus.load_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.Sgf_o !== 26'h0 || bus.Exp_o !== 8'd0 ||
            {bus.zero_o, bus.underflow_o, bus.lza_err_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL rst_mid: ready=%b done=%b Sgf=%h Exp=%0d, required 1/0/0/0",
                     bus.ready_o, bus.done_o, bus.Sgf_o, bus.Exp_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_stays_idle: ready=%b done=%b, required 1/0", bus.ready_o, bus.done_o);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        bus.load_i        = 1'b0;
        bus.ack_i         = 1'b0;
        bus.Sgf_i         = '0;
        bus.Exp_i         = '0;
        bus.Shift_Value_i = '0;
        test_reset();
        test_normal();
        test_correction();
        test_zero();
        test_underflow();
        test_lza_err();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
